// File: rtl/rom_load_arbiter.sv
// rtl/rom_load_arbiter.sv - ROM download / game read port arbiter with boot reset sequencing
//
// Shares the single port of the program/graphics ROM BRAM between the data_io
// download path and the game core's read path, and holds the game core in reset
// until a ROM image has been loaded and a short settle time has elapsed.
//
// Ports:
//   clk_sys, reset              system clock, asynchronous active-high reset
//   ioctl_downl/index/wr/addr/dout
//                               data_io download interface (byte strobes)
//   cpu_rd, cpu_addr            game read request (one-cycle pulse) and address
//   cpu_data, cpu_valid         read data (8'hFF outside RUN), valid one cycle after cpu_rd
//   rom_addr, rom_din, rom_we   BRAM port driven towards the ROM
//   rom_dout                    BRAM read data, one cycle latency
//   game_reset                  active-high reset to the game core
//   dl_busy                     high while a ROM download is being written
//   dl_overflow                 sticky flag: a download byte beyond 2**AW was dropped
module rom_load_arbiter #(
  parameter int unsigned AW           = 14,
  parameter logic [7:0]  ROM_INDEX    = 8'd0,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter bit          ROM_REQUIRED = 1'b1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_downl,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_addr,
  output logic [7:0]    cpu_data,
  output logic          cpu_valid,
  output logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_din,
  output logic          rom_we,
  input  logic [7:0]    rom_dout,
  output logic          game_reset,
  output logic          dl_busy,
  output logic          dl_overflow
);

  typedef enum logic [1:0] {
    ST_WAIT_DL = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_INIT   = 8'(HOLD_CYCLES - 1);
  localparam state_t     RESET_STATE = ROM_REQUIRED ? ST_WAIT_DL : ST_SETTLE;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    din_q, din_d;
  logic          we_q, we_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          dl;
  logic          addr_ok;

  assign dl      = ioctl_downl && (ioctl_index == ROM_INDEX);
  // Any address bit at or above AW set means the byte does not fit in the ROM.
  assign addr_ok = ((ioctl_addr >> AW) == 25'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    din_d     = din_q;
    we_d      = 1'b0;
    ovf_d     = ovf_q;
    // Sampled on the current state, so a read issued on the cycle RUN is left
    // still returns a valid strobe (with 8'hFF data, since the port is gone).
    valid_d   = (state_q == ST_RUN) && cpu_rd;

    // LOAD includes the cycle on which dl falls, so the last byte is not lost.
    if (state_q == ST_LOAD && ioctl_wr) begin
      if (addr_ok) begin
        we_d      = 1'b1;
        wr_addr_d = ioctl_addr[AW-1:0];
        din_d     = ioctl_dout;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_WAIT_DL: if (dl) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!dl) begin
          state_d = ST_SETTLE;
          cnt_d   = HOLD_INIT;
        end
      end
      ST_SETTLE: begin
        if (dl) begin
          state_d = ST_LOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RUN:  if (dl) state_d = ST_LOAD;
      default: state_d = RESET_STATE;
    endcase

    // A fresh download starts with a clean overflow flag.
    if (state_d == ST_LOAD && state_q != ST_LOAD) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      cnt_q     <= 8'd0;
      wr_addr_q <= '0;
      din_q     <= 8'd0;
      we_q      <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign rom_addr    = (state_q == ST_RUN) ? cpu_addr : wr_addr_q;
  assign rom_din     = din_q;
  assign rom_we      = we_q;
  assign cpu_valid   = valid_q;
  assign cpu_data    = (state_q == ST_RUN) ? rom_dout : 8'hFF;
  assign game_reset  = (state_q != ST_RUN);
  assign dl_busy     = (state_q == ST_LOAD);
  assign dl_overflow = ovf_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// tb/tb_rom_load_arbiter.sv - self-checking bench for rom_load_arbiter
module tb_rom_load_arbiter;

  localparam int         AW      = 14;
  localparam int         HOLD    = 16;
  localparam logic [7:0] ROM_IDX = 8'd0;
  localparam bit         ROM_REQ = 1'b1;

  localparam int PH_WAIT = 0, PH_LOAD = 1, PH_SETTLE = 2, PH_RUN = 3;

  logic          clk_sys, reset;
  logic          ioctl_downl, ioctl_wr, cpu_rd;
  logic [7:0]    ioctl_index, ioctl_dout;
  logic [24:0]   ioctl_addr;
  logic [AW-1:0] cpu_addr, rom_addr;
  logic [7:0]    cpu_data, rom_din, rom_dout;
  logic          cpu_valid, rom_we, game_reset, dl_busy, dl_overflow;

  int checks = 0;
  int errors = 0;

  rom_load_arbiter #(
    .AW(AW), .ROM_INDEX(ROM_IDX), .HOLD_CYCLES(HOLD), .ROM_REQUIRED(ROM_REQ)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_valid(cpu_valid),
    .rom_addr(rom_addr), .rom_din(rom_din), .rom_we(rom_we), .rom_dout(rom_dout),
    .game_reset(game_reset), .dl_busy(dl_busy), .dl_overflow(dl_overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ROM block RAM attached to the port
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (rom_we) mem[rom_addr] <= rom_din;
    rom_dout <= mem[rom_addr];
  end

  // Reference model: boot phase, release deadline in absolute edge numbers,
  // a shadow copy of the ROM contents and the expected port outputs.
  int            ph, edge_no, release_edge;
  logic [AW-1:0] m_wr_addr, rd_a;
  logic [7:0]    m_din, m_data;
  logic          m_we, m_ovf, m_valid;
  logic [7:0]    shadow [0:(1<<AW)-1];
  logic [AW-1:0] wq[$];
  logic [AW-1:0] exp_rom_addr;
  logic          exp_game_reset, exp_busy;

  task automatic model_reset();
    ph = ROM_REQ ? PH_WAIT : PH_SETTLE;
    release_edge = edge_no;
    m_wr_addr = '0; m_din = 8'd0; m_we = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    exp_game_reset = 1'b1; exp_busy = 1'b0;
  endtask

  task automatic drive(input logic downl, input logic [7:0] idx, input logic wr,
                       input logic [24:0] addr, input logic [7:0] dout,
                       input logic rd, input logic [AW-1:0] caddr);
    ioctl_downl = downl; ioctl_index = idx; ioctl_wr = wr;
    ioctl_addr = addr; ioctl_dout = dout; cpu_rd = rd; cpu_addr = caddr;
    #1;
    exp_rom_addr = (ph == PH_RUN) ? caddr : m_wr_addr;
  endtask

  task automatic advance();
    logic dl;
    @(posedge clk_sys);
    if (m_we) shadow[m_wr_addr] = m_din;
    dl = ioctl_downl && (ioctl_index == ROM_IDX);
    m_valid = (ph == PH_RUN) && cpu_rd;
    rd_a = cpu_addr;
    m_we = 1'b0;
    if (ph == PH_LOAD && ioctl_wr) begin
      if (ioctl_addr < (25'd1 << AW)) begin
        m_we = 1'b1; m_wr_addr = ioctl_addr[AW-1:0]; m_din = ioctl_dout;
        wq.push_back(ioctl_addr[AW-1:0]);
      end else begin
        m_ovf = 1'b1;
      end
    end
    case (ph)
      PH_WAIT:   if (dl) begin ph = PH_LOAD; m_ovf = 1'b0; end
      PH_LOAD:   if (!dl) begin ph = PH_SETTLE; release_edge = edge_no + HOLD; end
      PH_SETTLE: if (dl) begin ph = PH_LOAD; m_ovf = 1'b0; end
                 else if (edge_no >= release_edge) ph = PH_RUN;
      default:   if (dl) begin ph = PH_LOAD; m_ovf = 1'b0; end
    endcase
    edge_no++;
    m_data = (ph == PH_RUN) ? shadow[rd_a] : 8'hFF;
    exp_game_reset = (ph != PH_RUN);
    exp_busy = (ph == PH_LOAD);
    @(negedge clk_sys);
  endtask

  // Ends a download and returns how many edges pass until game_reset drops.
  task automatic release_count(output int k);
    k = 0;
    do begin
      drive(1'b0, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'b0, '0);
      advance();
      k++;
    end while (game_reset && k < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ioctl_downl = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
    cpu_rd = 0; cpu_addr = '0;
    edge_no = 0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    checks += 8;
    if (game_reset !== 1'b1) begin errors++; $display("FAIL reset_game_reset got %b exp 1", game_reset); end
    if (rom_we !== 1'b0) begin errors++; $display("FAIL reset_rom_we got %b exp 0", rom_we); end
    if (cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_cpu_valid got %b exp 0", cpu_valid); end
    if (dl_busy !== 1'b0) begin errors++; $display("FAIL reset_dl_busy got %b exp 0", dl_busy); end
    if (dl_overflow !== 1'b0) begin errors++; $display("FAIL reset_dl_overflow got %b exp 0", dl_overflow); end
    if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
    if (rom_din !== 8'd0) begin errors++; $display("FAIL reset_rom_din got %h exp 0", rom_din); end
    if (cpu_data !== 8'hFF) begin errors++; $display("FAIL reset_cpu_data got %h exp ff", cpu_data); end
    reset = 1'b0;
  endtask

  task automatic test_no_download();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0, 1'($urandom % 2), AW'($urandom));
      checks++;
      if (rom_addr !== exp_rom_addr) begin errors++; $display("FAIL idle_rom_addr got %h exp %h", rom_addr, exp_rom_addr); end
      advance();
      checks += 2;
      if (game_reset !== 1'b1 || game_reset !== exp_game_reset) begin errors++; $display("FAIL idle_game_reset got %b exp 1", game_reset); end
      if (cpu_valid !== m_valid) begin errors++; $display("FAIL idle_cpu_valid got %b exp %b", cpu_valid, m_valid); end
    end
  endtask

  task automatic test_download();
    int we_cnt, k;
    logic wr;
    drive(1'b1, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'b0, '0);
    advance();
    checks++;
    if (dl_busy !== 1'b1) begin errors++; $display("FAIL dl_busy_start got %b exp 1", dl_busy); end
    we_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, ROM_IDX, 1'b1, 25'(i), 8'(i), 1'b0, '0);
      advance();
      we_cnt += int'(rom_we);
      checks += 3;
      if (rom_we !== 1'b1) begin errors++; $display("FAIL seq_rom_we[%0d] got %b exp 1", i, rom_we); end
      if (rom_addr !== AW'(i)) begin errors++; $display("FAIL seq_rom_addr[%0d] got %h exp %h", i, rom_addr, i); end
      if (rom_din !== 8'(i)) begin errors++; $display("FAIL seq_rom_din[%0d] got %h exp %h", i, rom_din, i); end
    end
    checks++;
    if (we_cnt != 16) begin errors++; $display("FAIL seq_we_count got %0d exp 16", we_cnt); end
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom % 2);
      drive(1'b1, ROM_IDX, wr, 25'($urandom_range(16, 255)), 8'($urandom), 1'b0, '0);
      advance();
      checks += 2;
      if (rom_we !== m_we) begin errors++; $display("FAIL rnd_rom_we got %b exp %b", rom_we, m_we); end
      if (rom_addr !== m_wr_addr || rom_din !== m_din) begin
        errors++; $display("FAIL rnd_rom_wdata got %h/%h exp %h/%h", rom_addr, rom_din, m_wr_addr, m_din);
      end
    end
    release_count(k);
    checks += 2;
    if (k != HOLD + 1) begin errors++; $display("FAIL release_latency got %0d exp %0d", k, HOLD + 1); end
    if (game_reset !== exp_game_reset) begin errors++; $display("FAIL release_model got %b exp %b", game_reset, exp_game_reset); end
  endtask

  task automatic test_read();
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0, 1'b1, AW'(5));
    checks++;
    if (rom_addr !== AW'(5)) begin errors++; $display("FAIL rd5_rom_addr got %h exp 5", rom_addr); end
    advance();
    checks += 2;
    if (cpu_valid !== 1'b1) begin errors++; $display("FAIL rd5_cpu_valid got %b exp 1", cpu_valid); end
    if (cpu_data !== 8'h05) begin errors++; $display("FAIL rd5_cpu_data got %h exp 05", cpu_data); end
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0, 1'($urandom % 4 != 0), wq[$urandom % wq.size()]);
      checks++;
      if (rom_addr !== exp_rom_addr) begin errors++; $display("FAIL rd_rom_addr got %h exp %h", rom_addr, exp_rom_addr); end
      advance();
      checks++;
      if (cpu_valid !== m_valid) begin errors++; $display("FAIL rd_cpu_valid got %b exp %b", cpu_valid, m_valid); end
      if (m_valid) begin
        checks++;
        if (cpu_data !== m_data) begin errors++; $display("FAIL rd_cpu_data got %h exp %h", cpu_data, m_data); end
      end
    end
  endtask

  task automatic test_other_index();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'd3, 1'($urandom % 2), 25'($urandom % 16), 8'($urandom), 1'b0, '0);
      advance();
      checks += 3;
      if (rom_we !== 1'b0) begin errors++; $display("FAIL idx3_rom_we got %b exp 0", rom_we); end
      if (game_reset !== 1'b0) begin errors++; $display("FAIL idx3_game_reset got %b exp 0", game_reset); end
      if (dl_busy !== exp_busy) begin errors++; $display("FAIL idx3_dl_busy got %b exp %b", dl_busy, exp_busy); end
    end
  endtask

  task automatic test_read_on_exit();
    drive(1'b1, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'b1, AW'(5));
    advance();
    checks += 4;
    if (cpu_valid !== 1'b1) begin errors++; $display("FAIL exit_cpu_valid got %b exp 1", cpu_valid); end
    if (cpu_data !== 8'hFF) begin errors++; $display("FAIL exit_cpu_data got %h exp ff", cpu_data); end
    if (game_reset !== 1'b1) begin errors++; $display("FAIL exit_game_reset got %b exp 1", game_reset); end
    if (dl_busy !== 1'b1) begin errors++; $display("FAIL exit_dl_busy got %b exp 1", dl_busy); end
  endtask

  task automatic test_overflow();
    logic [24:0] a;
    drive(1'b1, ROM_IDX, 1'b1, 25'h4000, 8'hAA, 1'b0, '0);
    advance();
    checks += 2;
    if (rom_we !== 1'b0) begin errors++; $display("FAIL ovf_rom_we got %b exp 0", rom_we); end
    if (dl_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", dl_overflow); end
    for (int i = 0; i < 24; i++) begin
      a = ($urandom % 2) ? 25'($urandom_range(0, (1 << AW) - 1)) : 25'($urandom_range(1 << AW, (1 << 25) - 1));
      drive(1'b1, ROM_IDX, 1'($urandom % 2), a, 8'($urandom), 1'($urandom % 2), '0);
      advance();
      checks += 4;
      if (rom_we !== m_we) begin errors++; $display("FAIL mix_rom_we got %b exp %b", rom_we, m_we); end
      if (rom_addr !== m_wr_addr || rom_din !== m_din) begin
        errors++; $display("FAIL mix_rom_wdata got %h/%h exp %h/%h", rom_addr, rom_din, m_wr_addr, m_din);
      end
      if (dl_overflow !== m_ovf) begin errors++; $display("FAIL mix_ovf got %b exp %b", dl_overflow, m_ovf); end
      if (cpu_valid !== 1'b0) begin errors++; $display("FAIL mix_cpu_valid got %b exp 0", cpu_valid); end
    end
  endtask

  task automatic test_settle_reentry();
    int k;
    // falling edge enters SETTLE with count HOLD-1; 10 more edges reach count 5
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'($urandom % 2), AW'($urandom));
      advance();
      checks += 3;
      if (game_reset !== 1'b1) begin errors++; $display("FAIL settle_game_reset got %b exp 1", game_reset); end
      if (cpu_valid !== 1'b0) begin errors++; $display("FAIL settle_cpu_valid got %b exp 0", cpu_valid); end
      if (dl_overflow !== 1'b1) begin errors++; $display("FAIL settle_ovf_sticky got %b exp 1", dl_overflow); end
    end
    drive(1'b1, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'b0, '0);
    advance();
    checks += 2;
    if (dl_busy !== 1'b1) begin errors++; $display("FAIL reentry_dl_busy got %b exp 1", dl_busy); end
    if (dl_overflow !== 1'b0) begin errors++; $display("FAIL reentry_ovf_clear got %b exp 0", dl_overflow); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ROM_IDX, 1'b1, 25'(32 + i), 8'(8'hC0 + i), 1'b0, '0);
      advance();
    end
    release_count(k);
    checks++;
    if (k != HOLD + 1) begin errors++; $display("FAIL reentry_release got %0d exp %0d", k, HOLD + 1); end
  endtask

  task automatic test_reset_mid_load();
    int k;
    drive(1'b1, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'b0, '0);
    advance();
    drive(1'b1, ROM_IDX, 1'b1, 25'd7, 8'h77, 1'b0, '0);
    advance();
    checks++;
    if (rom_we !== 1'b1) begin errors++; $display("FAIL pre_reset_rom_we got %b exp 1", rom_we); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks += 4;
    if (rom_we !== 1'b0) begin errors++; $display("FAIL midreset_rom_we got %b exp 0", rom_we); end
    if (game_reset !== 1'b1) begin errors++; $display("FAIL midreset_game_reset got %b exp 1", game_reset); end
    if (dl_busy !== 1'b0) begin errors++; $display("FAIL midreset_dl_busy got %b exp 0", dl_busy); end
    if (rom_addr !== '0 || rom_din !== 8'd0) begin errors++; $display("FAIL midreset_wport got %h/%h exp 0/0", rom_addr, rom_din); end
    ioctl_downl = 1'b0; ioctl_wr = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'b1, '0);
      advance();
      checks += 2;
      if (game_reset !== exp_game_reset) begin errors++; $display("FAIL postreset_game_reset got %b exp %b", game_reset, exp_game_reset); end
      if (cpu_valid !== 1'b0) begin errors++; $display("FAIL postreset_cpu_valid got %b exp 0", cpu_valid); end
    end
    drive(1'b1, ROM_IDX, 1'b0, 25'd0, 8'd0, 1'b0, '0);
    advance();
    drive(1'b1, ROM_IDX, 1'b1, 25'd3, 8'h5A, 1'b0, '0);
    advance();
    release_count(k);
    checks++;
    if (k != HOLD + 1) begin errors++; $display("FAIL postreset_release got %0d exp %0d", k, HOLD + 1); end
  endtask

  initial begin
    test_reset();
    test_no_download();
    test_download();
    test_read();
    test_other_index();
    test_read_on_exit();
    test_overflow();
    test_settle_reentry();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_load_arbiter.md
# rom_load_arbiter

Shares the single write/read port of the game's program/graphics ROM block RAM between the MiST ROM-download path (data_io ioctl interface) and the game core's read path in the clk_sys (24.192 MHz) domain. It sequences boot: holds the game core in reset until the ROM image is loaded, then hands the port to the core. It sits between data_io, the ROM BRAM and the game core's reset input in the arcade top level.

## Interface
Parameters:
- AW, 14, ROM address width; capacity 2**AW bytes.
- ROM_INDEX, 8'd0, ioctl_index value accepted as ROM download.
- HOLD_CYCLES, 16, clk_sys cycles game_reset stays high after download ends (1..255).
- ROM_REQUIRED, 1, 1: wait for download after reset; 0: go straight to SETTLE.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_downl  in  1  download in progress.
- ioctl_index  in  8  download slot index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- cpu_rd  in  1  game read request (one-cycle pulse).
- cpu_addr  in  AW  game read address.
- cpu_data  out  8  read data; rom_dout in RUN, 8'hFF otherwise.
- cpu_valid  out  1  cpu_data valid for the request issued one cycle earlier.
- rom_addr  out  AW  BRAM address.
- rom_din  out  8  BRAM write data.
- rom_we  out  1  BRAM write enable.
- rom_dout  in  8  BRAM read data (synchronous, 1-cycle latency).
- game_reset  out  1  active-high reset to game core.
- dl_busy  out  1  high in LOAD.
- dl_overflow  out  1  sticky: a write with ioctl_addr >= 2**AW was dropped.

## Operation
- Download qualified: dl = ioctl_downl && ioctl_index == ROM_INDEX. Other indices are ignored in all states.
- States:
  - WAIT_DL: game_reset=1. On dl go to LOAD.
  - LOAD: dl_busy=1, game_reset=1. The port is owned by ioctl; cpu_rd is ignored. When dl falls, go to SETTLE.
  - SETTLE: game_reset=1. An 8-bit counter loads HOLD_CYCLES-1 on entry and decrements; at 0 go to RUN. dl high returns to LOAD and the counter is abandoned.
  - RUN: game_reset=0. The port is owned by the core. dl high goes to LOAD, and game_reset rises the same cycle the state changes.
- After reset, state is WAIT_DL if ROM_REQUIRED=1, else SETTLE.
- Write path, valid in LOAD and on the cycle dl falls:
  - ioctl_wr with ioctl_addr < 2**AW: register rom_addr = ioctl_addr[AW-1:0], rom_din = ioctl_dout, rom_we = 1 for exactly one cycle.
  - Out-of-range address: no write; set dl_overflow. dl_overflow clears only on reset or on the next entry into LOAD.
- Read path in RUN:
  - rom_addr = cpu_addr combinationally.
  - cpu_valid = cpu_rd registered.
  - cpu_data = rom_dout.
- Outside RUN: rom_addr is the registered write address, cpu_valid = 0.
- A cpu_rd on the cycle RUN transitions to LOAD yields cpu_valid = 1 next cycle, with cpu_data = 8'hFF.

## Timing
- Reset values:
  - game_reset = 1; rom_we, cpu_valid, dl_busy, dl_overflow = 0.
  - rom_addr = 0, rom_din = 0, counter = 0.
- Write latency: ioctl_wr at cycle n produces rom_we at n+1. Back-to-back ioctl_wr every cycle is supported, giving one write per cycle.
- Read latency: cpu_rd at n produces cpu_valid plus data at n+1. Back-to-back reads are supported.
- Release latency: dl falls at cycle n, SETTLE is entered at n+1, and game_reset falls at n+1+HOLD_CYCLES.
- Reset asserted mid-LOAD or mid-SETTLE:
  - All outputs immediately take their reset values.
  - A pending rom_we is cancelled.
  - After release, state follows ROM_REQUIRED.

## Test plan
- ROM_REQUIRED=1, reset released, no download: game_reset stays 1 for 1000 cycles, and cpu_rd gives cpu_valid=0.
- Download index 0, bytes 0x00..0x0F at addresses 0..15 on consecutive cycles: rom_we high 16 cycles, each one cycle after its ioctl_wr, with matching rom_addr/rom_din. Then ioctl_downl falls, and game_reset falls exactly 17 cycles later (HOLD_CYCLES=16).
- In RUN, cpu_rd with cpu_addr=5: rom_addr=5 the same cycle, cpu_valid=1 next cycle with cpu_data = 0x05.
- Download with ioctl_index=3 during RUN: no state change, rom_we stays 0, game_reset stays 0.
- Write at ioctl_addr=0x4000 (AW=14): no rom_we and dl_overflow=1. A new download start clears dl_overflow to 0.
- ioctl_downl re-rises at SETTLE count 5: state returns to LOAD. After it falls again, game_reset falls 17 cycles later. Reset pulsed mid-LOAD: rom_we=0 and game_reset=1 immediately.
